// File: rtl/rsa_mem_pkg.sv
// Shared constants and sizing helpers for the RSA operand memory path.
package rsa_mem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    DRAIN = ST_DRAIN
  } state_t;

  function automatic int nwords(input int bitlen, input int dbits);
    return bitlen / dbits;
  endfunction

  function automatic int cntw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// Delay line of the RAM read enable; the tap at DEPTH-1 marks data ready to capture.
module rd_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic vin,
  output logic vout
);

  // Stage 0 is vin itself, so only DEPTH-1 registers are needed.
  logic [DEPTH-2:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= vin;
      for (int k = 1; k < DEPTH - 1; k++) begin
        sr[k] <= sr[k-1];
      end
    end
  end

  assign vout = sr[DEPTH-2];

endmodule

// File: rtl/mem_operand_loader.sv
// Streams NWORDS consecutive RAM words into one BITLEN-bit operand, then pulses done.
module mem_operand_loader
  import rsa_mem_pkg::*;
#(
  parameter int ABITS  = 8,
  parameter int DBITS  = 16,
  parameter int BITLEN = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ABITS-1:0]  base_addr,
  input  logic              msw_first,
  output logic              rd_en,
  output logic [ABITS-1:0]  rd_addr,
  input  logic [DBITS-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [BITLEN-1:0] out
);

  localparam int NW = nwords(BITLEN, DBITS);
  localparam int CW = cntw(NW);
  localparam logic [CW-1:0] NW_C   = CW'(NW);
  localparam logic [CW-1:0] LAST_C = CW'(NW - 1);

  if ((BITLEN % DBITS) != 0 || NW < 1) begin : g_bitlen_check
    $fatal(1, "mem_operand_loader: BITLEN must be a nonzero multiple of DBITS");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_lat_check
    $fatal(1, "mem_operand_loader: RD_LAT must be 1 or 2");
  end

  state_t            state;
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     cap_cnt;
  logic [CW-1:0]     slot;
  logic              msw_q;
  logic              cap_stb;
  logic [BITLEN-1:0] shadow;
  logic [BITLEN-1:0] merged;

  rd_valid_pipe #(.DEPTH(RD_LAT + 1)) u_vpipe (
    .clk  (clk),
    .rst  (rst),
    .vin  (rd_en),
    .vout (cap_stb)
  );

  always_comb begin
    slot   = msw_q ? (LAST_C - cap_cnt) : cap_cnt;
    merged = shadow;
    for (int k = 0; k < NW; k++) begin
      if (slot == CW'(k)) merged[k*DBITS +: DBITS] = rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= '0;
      shadow    <= '0;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      msw_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            rd_en     <= 1'b1;
            rd_addr   <= base_addr;
            msw_q     <= msw_first;
            busy      <= 1'b1;
            issue_cnt <= CW'(1);
            cap_cnt   <= '0;
          end
        end
        ISSUE: begin
          if (issue_cnt == NW_C) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr   <= rd_addr + ABITS'(1);
            issue_cnt <= issue_cnt + CW'(1);
          end
        end
        DRAIN: ;
        default: state <= IDLE;
      endcase

      if (cap_stb && state != IDLE) begin
        shadow <= merged;
        if (cap_cnt == LAST_C) begin
          out     <= merged;
          done    <= 1'b1;
          cap_cnt <= '0;
          // The final-capture edge already counts as idle, so a waiting start
          // launches the next fetch with no dead cycle between operands.
          if (start) begin
            state     <= ISSUE;
            rd_en     <= 1'b1;
            rd_addr   <= base_addr;
            msw_q     <= msw_first;
            issue_cnt <= CW'(1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end else begin
          cap_cnt <= cap_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_operand_loader.sv
// Scoreboard bench: two loaders (read latency 1 and 2) against behavioural RAMs.
module tb_mem_operand_loader;

  localparam int N = 4;

  typedef struct packed {
    logic [63:0] val;
    logic [31:0] cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [256];

  logic        a_start = 0, a_msw = 0, a_rd_en, a_busy, a_done;
  logic [7:0]  a_base = 0, a_rd_addr;
  logic [15:0] a_rd_data, a_q1;
  logic [63:0] a_out;
  logic        b_start = 0, b_msw = 0, b_rd_en, b_busy, b_done;
  logic [7:0]  b_base = 0, b_rd_addr;
  logic [15:0] b_rd_data, b_q1, b_q2;
  logic [63:0] b_out;

  mem_operand_loader #(.ABITS(8), .DBITS(16), .BITLEN(64), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .base_addr(a_base), .msw_first(a_msw),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .busy(a_busy), .done(a_done), .out(a_out));

  mem_operand_loader #(.ABITS(8), .DBITS(16), .BITLEN(64), .RD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .base_addr(b_base), .msw_first(b_msw),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .busy(b_busy), .done(b_done), .out(b_out));

  always @(posedge clk) begin
    if (a_rd_en) a_q1 <= mem[a_rd_addr];
    if (b_rd_en) b_q1 <= mem[b_rd_addr];
    b_q2 <= b_q1;
  end
  assign a_rd_data = a_q1;
  assign b_rd_data = b_q2;

  logic [7:0] a_addr_q [$];
  logic [7:0] b_addr_q [$];
  res_t       a_res_q  [$];
  res_t       b_res_q  [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with no expectation (cycle %0d)", name, cyc);
  endtask

  // Monitor: compare every read address and every done pulse against the queues.
  logic [7:0] a_ea, b_ea;
  res_t       a_er, b_er;
  always @(negedge clk) begin
    if (a_rd_en) begin
      if (a_addr_q.size() == 0) unexpected("a_rd_addr");
      else begin a_ea = a_addr_q.pop_front(); check("a_rd_addr", 64'(a_rd_addr), 64'(a_ea)); end
    end
    if (b_rd_en) begin
      if (b_addr_q.size() == 0) unexpected("b_rd_addr");
      else begin b_ea = b_addr_q.pop_front(); check("b_rd_addr", 64'(b_rd_addr), 64'(b_ea)); end
    end
    if (a_done) begin
      if (a_res_q.size() == 0) unexpected("a_done");
      else begin
        a_er = a_res_q.pop_front();
        check("a_out", a_out, a_er.val);
        check("a_done_cycle", 64'(cyc), 64'(a_er.cyc));
      end
    end
    if (b_done) begin
      if (b_res_q.size() == 0) unexpected("b_done");
      else begin
        b_er = b_res_q.pop_front();
        check("b_out", b_out, b_er.val);
        check("b_done_cycle", 64'(cyc), 64'(b_er.cyc));
      end
    end
  end

  task automatic push_addrs_a(input logic [7:0] base, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin a = base + 8'(i); a_addr_q.push_back(a); end
  endtask

  task automatic push_addrs_b(input logic [7:0] base, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin a = base + 8'(i); b_addr_q.push_back(a); end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((a_addr_q.size() + b_addr_q.size() + a_res_q.size() + b_res_q.size()) != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (t >= 100) unexpected("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; the start is accepted on the next edge.
  task automatic a_fetch(input logic [7:0] base, input logic msw, input logic [63:0] exp);
    res_t r;
    a_base = base; a_msw = msw; a_start = 1'b1;
    push_addrs_a(base, N);
    r.val = exp; r.cyc = 32'(cyc + 1 + N + 1);
    a_res_q.push_back(r);
    @(posedge clk); #1 a_start = 1'b0;
    wait_drain();
    check("a_busy_idle", 64'(a_busy), 64'd0);
  endtask

  initial begin
    res_t r;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h10] = 16'h1111; mem[8'h11] = 16'h2222; mem[8'h12] = 16'h3333; mem[8'h13] = 16'h4444;
    mem[8'hFE] = 16'hAAAA; mem[8'hFF] = 16'hBBBB; mem[8'h00] = 16'hCCCC; mem[8'h01] = 16'hDDDD;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out",     a_out,            64'd0);
    check("rst_busy",    64'(a_busy),      64'd0);
    check("rst_rd_en",   64'(a_rd_en),     64'd0);
    check("rst_rd_addr", 64'(a_rd_addr),   64'd0);
    check("rst_done",    64'(a_done),      64'd0);
    check("rst_b_out",   b_out,            64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    a_fetch(8'h10, 1'b0, 64'h4444_3333_2222_1111);
    a_fetch(8'h10, 1'b1, 64'h1111_2222_3333_4444);
    a_fetch(8'hFE, 1'b0, 64'hDDDD_CCCC_BBBB_AAAA);

    // Latency 2, with stray starts while busy that must cause no extra reads.
    b_base = 8'h10; b_msw = 1'b0; b_start = 1'b1;
    push_addrs_b(8'h10, N);
    r.val = 64'h4444_3333_2222_1111; r.cyc = 32'(cyc + 1 + N + 2);
    b_res_q.push_back(r);
    @(posedge clk); #1 b_start = 1'b0;
    @(posedge clk); #1 b_start = 1'b1; b_base = 8'h40;
    @(posedge clk); #1 b_start = 1'b0;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    wait_drain();
    check("b_busy_idle", 64'(b_busy), 64'd0);

    // Reset three edges into a fetch: only three addresses go out, no done.
    a_base = 8'h10; a_msw = 1'b0; a_start = 1'b1;
    push_addrs_a(8'h10, 3);
    @(posedge clk); #1 a_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out",   a_out,        64'd0);
    check("abort_busy",  64'(a_busy),  64'd0);
    check("abort_rd_en", 64'(a_rd_en), 64'd0);
    check("abort_done",  64'(a_done),  64'd0);
    #2 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_addr_left", 64'(a_addr_q.size()), 64'd0);
    a_fetch(8'h10, 1'b0, 64'h4444_3333_2222_1111);

    // Start held through done: second fetch launches on the done edge.
    a_base = 8'h10; a_msw = 1'b0; a_start = 1'b1;
    push_addrs_a(8'h10, N);
    r.val = 64'h4444_3333_2222_1111; r.cyc = 32'(cyc + 1 + N + 1);
    a_res_q.push_back(r);
    r.val = 64'hAAAA_BBBB_CCCC_DDDD; r.cyc = 32'(cyc + 1 + 2 * (N + 1));
    a_res_q.push_back(r);
    @(posedge clk); #1;
    a_base = 8'hFE; a_msw = 1'b1;
    push_addrs_a(8'hFE, N);
    repeat (N + 1) @(posedge clk);
    #1 a_start = 1'b0;
    wait_drain();
    check("b2b_busy_idle", 64'(a_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
